// File: rtl/hx711_scale_ctrl.sv
// hx711_scale_ctrl: burst sequencer above the HX711 serial receiver.
// Requests conversions, selects channel/gain through the trailing pulse
// count, averages 2^AVG_LOG2 samples per burst, then either captures a tare
// offset or publishes a tare-corrected weight. Between bursts the sensor is
// powered down through rx_en, and a stalled sensor is caught by a timeout.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   enable          run bursts while high
//   tare_req        pulse: a pending tare is applied to the next burst
//   gain_sel        00=A/128, 01=A/64, 10=B/32, 11 behaves as 00
//   raw_valid/data  one-cycle sample strobe and 24-bit signed sample
//   conv_start      one-cycle conversion request to the receiver
//   extra_pulses    trailing PD_SCK pulse count for the receiver (1/3/2)
//   rx_en           HX711 power enable (low while sleeping)
//   weight/_valid   signed tare-corrected average with one-cycle strobe
//   tare_value      current tare offset, tare_done one-cycle strobe
//   timeout_err     sticky, cleared while enable is low
module hx711_scale_ctrl #(
  parameter int AVG_LOG2       = 2,
  parameter int SLEEP_CYCLES   = 1000,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        tare_req,
  input  logic [1:0]  gain_sel,
  input  logic        raw_valid,
  input  logic [23:0] raw_data,
  output logic        conv_start,
  output logic [1:0]  extra_pulses,
  output logic        rx_en,
  output logic [31:0] weight,
  output logic        weight_valid,
  output logic [23:0] tare_value,
  output logic        tare_done,
  output logic        timeout_err
);

  localparam int ACC_W = 24 + AVG_LOG2;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SL_W  = $clog2(SLEEP_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SL_W-1:0] SL_LAST = SL_W'(SLEEP_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_SLEEP = 3'd4;

  // Divide the burst sum by the sample count (arithmetic shift) and keep
  // the low 24 bits; the average of 24-bit samples always fits.
  function automatic logic signed [23:0] avg_of(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] sh;
    sh = sum >>> AVG_LOG2;
    return sh[23:0];
  endfunction

  function automatic logic [1:0] pulses_for(input logic [1:0] g);
    case (g)
      2'b01:   return 2'd3;
      2'b10:   return 2'd2;
      default: return 2'd1;
    endcase
  endfunction

  logic [2:0]              state;
  logic signed [ACC_W-1:0] acc;
  logic [AVG_LOG2-1:0]     smp_cnt;
  logic [TO_W-1:0]         to_cnt;
  logic [SL_W-1:0]         sleep_cnt;
  logic                    tare_pending;
  logic                    tare_burst;

  logic signed [ACC_W-1:0] raw_ext;
  logic signed [23:0]      avg;
  logic signed [31:0]      diff;

  assign raw_ext = {{AVG_LOG2{raw_data[23]}}, raw_data};
  assign avg     = avg_of(acc);
  assign diff    = {{8{avg[23]}}, avg} - {{8{tare_value[23]}}, tare_value};

  assign conv_start = (state == S_REQ);
  assign rx_en      = (state != S_SLEEP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      acc          <= '0;
      smp_cnt      <= '0;
      to_cnt       <= '0;
      sleep_cnt    <= '0;
      tare_pending <= 1'b0;
      tare_burst   <= 1'b0;
      extra_pulses <= 2'd1;
      weight       <= '0;
      weight_valid <= 1'b0;
      tare_value   <= '0;
      tare_done    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      weight_valid <= 1'b0;
      tare_done    <= 1'b0;
      if (tare_req) tare_pending <= 1'b1;
      if (!enable)  timeout_err  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (enable) begin
            extra_pulses <= pulses_for(gain_sel);
            // A tare request arriving on this very edge belongs to this burst.
            tare_burst   <= tare_pending | tare_req;
            tare_pending <= 1'b0;
            acc          <= '0;
            smp_cnt      <= '0;
            state        <= S_REQ;
          end
        end
        S_REQ: begin
          if (!enable) begin
            acc   <= '0;
            state <= S_IDLE;
            // An aborted tare burst keeps its request for the next burst.
            if (tare_burst) tare_pending <= 1'b1;
          end else begin
            to_cnt <= '0;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!enable) begin
            acc   <= '0;
            state <= S_IDLE;
            if (tare_burst) tare_pending <= 1'b1;
          end else if (raw_valid) begin
            acc <= acc + raw_ext;
            if (&smp_cnt) begin
              state <= S_DONE;
            end else begin
              smp_cnt <= smp_cnt + 1'b1;
              state   <= S_REQ;
            end
          end else if (to_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            acc         <= '0;
            sleep_cnt   <= '0;
            state       <= S_SLEEP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (tare_burst) begin
            tare_value <= avg;
            tare_done  <= 1'b1;
          end else begin
            weight       <= diff;
            weight_valid <= 1'b1;
          end
          sleep_cnt <= '0;
          state     <= S_SLEEP;
        end
        S_SLEEP: begin
          if (sleep_cnt == SL_LAST) begin
            state <= S_IDLE;
          end else begin
            sleep_cnt <= sleep_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hx711_scale_ctrl.sv
// Scoreboard bench for hx711_scale_ctrl: the stimulus side pushes the
// expected strobe (kind, value, cycle) per burst, an independent monitor
// pops and compares whenever weight_valid or tare_done appears.
module tb_hx711_scale_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        tare_req = 1'b0;
  logic [1:0]  gain_sel = 2'd0;
  logic        raw_valid = 1'b0;
  logic [23:0] raw_data = 24'd0;
  logic        conv_start;
  logic [1:0]  extra_pulses;
  logic        rx_en;
  logic [31:0] weight;
  logic        weight_valid;
  logic [23:0] tare_value;
  logic        tare_done;
  logic        timeout_err;

  always #5 clk = ~clk;

  hx711_scale_ctrl #(
    .AVG_LOG2(2),
    .SLEEP_CYCLES(1000),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .tare_req(tare_req),
    .gain_sel(gain_sel),
    .raw_valid(raw_valid),
    .raw_data(raw_data),
    .conv_start(conv_start),
    .extra_pulses(extra_pulses),
    .rx_en(rx_en),
    .weight(weight),
    .weight_valid(weight_valid),
    .tare_value(tare_value),
    .tare_done(tare_done),
    .timeout_err(timeout_err)
  );

  typedef struct {
    bit          is_tare;
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   cs_count = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (conv_start) cs_count <= cs_count + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && (weight_valid || tare_done)) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got weight_valid=%0b tare_done=%0b expected no strobe",
                 weight_valid, tare_done);
      end else begin
        mon_e = sbq.pop_front();
        check("strobe_tare_done", {31'd0, tare_done}, {31'd0, mon_e.is_tare});
        check("strobe_weight_valid", {31'd0, weight_valid}, {31'd0, !mon_e.is_tare});
        if (mon_e.is_tare) check("tare_value", {8'd0, tare_value}, mon_e.val);
        else               check("weight", weight, mon_e.val);
        check("strobe_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic wait_cs();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (conv_start) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL conv_start_wait: got none in 3000 cycles expected a request");
    end
  endtask

  task automatic feed(input logic [23:0] d, input bit pulse_tare, output int c0);
    wait_cs();
    @(negedge clk);
    raw_valid = 1'b1;
    raw_data  = d;
    tare_req  = pulse_tare;
    @(negedge clk);
    raw_valid = 1'b0;
    tare_req  = 1'b0;
    c0 = cyc;
  endtask

  task automatic run_burst(input logic [23:0] s0, input logic [23:0] s1,
                           input logic [23:0] s2, input logic [23:0] s3,
                           input bit is_tare, input logic [31:0] exp_val,
                           input logic [1:0] exp_extra, input int tare_at);
    logic [23:0] s[4];
    int   c0;
    int   cs0;
    exp_t e;
    s   = '{s0, s1, s2, s3};
    cs0 = cs_count;
    c0  = 0;
    wait_cs();
    check("extra_pulses", {30'd0, extra_pulses}, {30'd0, exp_extra});
    for (int i = 0; i < 4; i++) feed(s[i], (tare_at == i), c0);
    e.is_tare = is_tare;
    e.val     = exp_val;
    e.cyc     = c0 + 1;
    sbq.push_back(e);
    check("conv_start_count", cs_count - cs0, 32'd4);
  endtask

  task automatic measure_sleep(input int exp_len);
    int n;
    int guard;
    n = 0;
    guard = 0;
    while (rx_en && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    while (!rx_en && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("sleep_len", n, exp_len);
  endtask

  task automatic wait_rx(input logic lvl);
    for (int i = 0; i < 3000; i++) begin
      if (rx_en == lvl) break;
      @(negedge clk);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int cs_a;
    c = 0;
    @(negedge clk);
    check("rst_conv_start", {31'd0, conv_start}, 32'd0);
    check("rst_rx_en", {31'd0, rx_en}, 32'd1);
    check("rst_extra_pulses", {30'd0, extra_pulses}, 32'd1);
    check("rst_weight", weight, 32'd0);
    check("rst_weight_valid", {31'd0, weight_valid}, 32'd0);
    check("rst_tare_value", {8'd0, tare_value}, 32'd0);
    check("rst_tare_done", {31'd0, tare_done}, 32'd0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Tare burst requested together with enable.
    @(negedge clk);
    enable   = 1'b1;
    tare_req = 1'b1;
    @(negedge clk);
    tare_req = 1'b0;
    run_burst(24'd100, 24'd102, 24'd98, 24'd100, 1'b1, 32'd100, 2'd1, -1);

    // Weight burst, then sleep length.
    run_burst(24'd600, 24'd600, 24'd600, 24'd600, 1'b0, 32'd500, 2'd1, -1);
    measure_sleep(1000);
    check("tare_hold", {8'd0, tare_value}, 32'd100);

    // Negative samples over three gain settings.
    run_burst(24'hFFFFF0, 24'hFFFFF0, 24'hFFFFF0, 24'hFFFFF0, 1'b0, 32'hFFFFFF8C, 2'd1, -1);
    gain_sel = 2'b01;
    run_burst(24'hFFFFF0, 24'hFFFFF0, 24'hFFFFF0, 24'hFFFFF0, 1'b0, 32'hFFFFFF8C, 2'd3, -1);
    gain_sel = 2'b10;
    run_burst(24'hFFFFF0, 24'hFFFFF0, 24'hFFFFF0, 24'hFFFFF0, 1'b0, 32'hFFFFFF8C, 2'd2, -1);

    // Stalled sensor.
    wait_cs();
    repeat (50) @(posedge clk);
    #1;
    check("timeout_before", {31'd0, timeout_err}, 32'd0);
    @(posedge clk);
    #1;
    check("timeout_set", {31'd0, timeout_err}, 32'd1);
    check("timeout_sleep", {31'd0, rx_en}, 32'd0);
    @(negedge clk);
    enable   = 1'b0;
    gain_sel = 2'b00;
    @(posedge clk);
    #1;
    check("timeout_clear", {31'd0, timeout_err}, 32'd0);
    wait_rx(1'b1);
    cs_a = cs_count;
    repeat (10) @(negedge clk);
    check("idle_no_request", cs_count, cs_a);

    // Abort after two samples, then a clean burst.
    enable = 1'b1;
    feed(24'd5000, 1'b0, c);
    feed(24'd5000, 1'b0, c);
    wait_cs();
    enable = 1'b0;
    cs_a = cs_count;
    repeat (5) @(negedge clk);
    check("abort_rx_en", {31'd0, rx_en}, 32'd1);
    check("abort_no_request", cs_count, cs_a + 1);
    enable = 1'b1;
    run_burst(24'd200, 24'd200, 24'd200, 24'd200, 1'b0, 32'd100, 2'd1, -1);

    // Tare request mid-burst applies to the following burst.
    run_burst(24'd300, 24'd300, 24'd300, 24'd300, 1'b0, 32'd200, 2'd1, 1);
    run_burst(24'd300, 24'd300, 24'd304, 24'd300, 1'b1, 32'd301, 2'd1, -1);
    wait_rx(1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      raw_valid = 1'b1;
      raw_data  = 24'h7FFFFF;
      @(negedge clk);
      raw_valid = 1'b0;
    end
    run_burst(24'd401, 24'd401, 24'd401, 24'd401, 1'b0, 32'd100, 2'd1, -1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 32'd0);
    check("tare_final", {8'd0, tare_value}, 32'd301);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
